// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the 16-bit register-file / ALU / data-memory datapath.
// Takes one instruction per handshake and walks it through DECODE/EXECUTE/MEM/WRITEBACK.
module multicycle_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            instr_ready,
  input  logic [15:0]     alu_result,
  input  logic [2:0]      alu_comp,
  output logic [3:0]      rf_aaddr,
  output logic [3:0]      rf_baddr,
  output logic [3:0]      rf_caddr,
  output logic            rf_load,
  output logic            rf_wsel,
  output logic            alu_op,
  output logic [2:0]      alu_control,
  output logic            alu_src,
  output logic [15:0]     imm,
  output logic [3:0]      mem_addr,
  output logic            mem_read,
  output logic            mem_load,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK
  } state_t;

  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b0101;
  localparam logic [3:0] OP_STORE = 4'b0110;
  localparam logic [3:0] OP_JUMP  = 4'b1000;

  state_t          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      mem_addr_q, mem_addr_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      op;
  logic            op_illegal, op_mem;
  logic [PC_W-1:0] pc_inc, pc_br, off_ext;
  logic            unused_alu_hi;

  assign op         = ir_q[15:12];
  // Opcodes 0..8 are all defined, so anything above JUMP is undefined.
  assign op_illegal = (op > OP_JUMP);
  assign op_mem     = (op == OP_LOAD) || (op == OP_STORE);
  assign off_ext    = {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
  assign pc_inc     = pc_q + PC_W'(1);
  assign pc_br      = pc_inc + off_ext;
  assign unused_alu_hi = ^alu_result[15:4];

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_illegal) begin
          illegal_d = 1'b1;
          pc_d      = pc_inc;
          state_d   = S_IDLE;
        end else if (op == OP_JUMP) begin
          pc_d    = ir_q[PC_W-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (op_mem) begin
          mem_addr_d = alu_result[3:0];
          state_d    = S_MEM;
        end else if (op == OP_BEQ) begin
          pc_d    = (alu_comp == 3'b010) ? pc_br : pc_inc;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (op == OP_LOAD) begin
          state_d = S_WRITEBACK;
        end else begin
          pc_d    = pc_inc;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        pc_d    = pc_inc;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      pc_q       <= '0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  // Datapath controls decode straight from the instruction register so they
  // stay constant for the whole instruction.
  always_comb begin
    alu_control = 3'b000;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: alu_control = op[2:0];
      OP_LOAD, OP_STORE:                           alu_control = 3'b010;
      OP_BEQ:                                      alu_control = 3'b011;
      default:                                     alu_control = 3'b000;
    endcase
  end

  assign rf_aaddr    = ir_q[7:4];
  assign rf_baddr    = ((op == OP_STORE) || (op == OP_BEQ)) ? ir_q[11:8] : ir_q[3:0];
  assign rf_caddr    = ir_q[11:8];
  assign rf_wsel     = (op == OP_LOAD);
  assign alu_src     = op_mem;
  assign imm         = {{12{ir_q[3]}}, ir_q[3:0]};
  assign mem_addr    = mem_addr_q;

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_op      = (state_q == S_EXECUTE);
  assign mem_read    = (state_q == S_MEM) && (op == OP_LOAD);
  assign mem_load    = (state_q == S_MEM) && (op == OP_STORE);
  assign rf_load     = (state_q == S_WRITEBACK);
  assign pc          = pc_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule
